// File: rtl/tinyalu_pkg.sv
// Shared types for the TinyALU command driver.
//   operation_t  : TinyALU opcode encoding
//   drv_state_t  : command driver FSM states
//   CmdWidth     : width of a queued command {op, a, b}
//   is_legal_op  : true for opcodes the ALU implements
package tinyalu_pkg;

  typedef enum logic [2:0] {
    no_op  = 3'b000,
    add_op = 3'b001,
    and_op = 3'b010,
    xor_op = 3'b011,
    mul_op = 3'b100
  } operation_t;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    NOOP,
    HOLD
  } drv_state_t;

  localparam int unsigned CmdWidth = 19;

  function automatic logic is_legal_op(input logic [2:0] op);
    return op <= 3'b100;
  endfunction

endpackage

// File: rtl/tinyalu_cmd_fifo.sv
// Synchronous FIFO holding queued ALU commands.
//   clk, reset_n : clock, asynchronous active-low reset (empties the FIFO)
//   push, wdata  : write an entry (ignored while full)
//   pop, rdata   : remove the head entry (ignored while empty); rdata shows the head
//   full, empty  : occupancy flags
//   level        : number of entries held
module tinyalu_cmd_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 19
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned LW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wptr_q, rptr_q;
  logic [LW-1:0]    level_q;
  logic             push_ok, pop_ok;

  assign full    = (level_q == LW'(DEPTH));
  assign empty   = (level_q == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign rdata   = mem_q[rptr_q];
  assign level   = level_q;

  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wptr_q] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + AW'(1);
      if (pop_ok)  rptr_q <= rptr_q + AW'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   level_q <= level_q + LW'(1);
        2'b01:   level_q <= level_q - LW'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: rtl/tinyalu_cmd_driver.sv
// Command driver in front of the TinyALU: queues commands, issues them one at a time
// on the start/done handshake and returns each result on a response stream.
//   clk, reset_n                   : clock, asynchronous active-low reset
//   cmd_valid/ready, cmd_a/b/op    : command stream in
//   alu_a/b/op, alu_start          : ALU command port (registered)
//   alu_done, alu_result           : ALU completion
//   rsp_valid/ready, rsp_result/op : response stream out; rsp_err flags a timeout abort
//   illegal_op                     : one-cycle pulse when an illegal opcode is dropped
//   fifo_level                     : queued command count
module tinyalu_cmd_driver
  import tinyalu_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned TIMEOUT    = 16
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic                          cmd_valid,
  output logic                          cmd_ready,
  input  logic [7:0]                    cmd_a,
  input  logic [7:0]                    cmd_b,
  input  logic [2:0]                    cmd_op,
  output logic [7:0]                    alu_a,
  output logic [7:0]                    alu_b,
  output logic [2:0]                    alu_op,
  output logic                          alu_start,
  input  logic                          alu_done,
  input  logic [15:0]                   alu_result,
  output logic                          rsp_valid,
  input  logic                          rsp_ready,
  output logic [15:0]                   rsp_result,
  output logic [2:0]                    rsp_op,
  output logic                          rsp_err,
  output logic                          illegal_op,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level
);

  localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  drv_state_t          state_q, state_d;
  logic [7:0]          alu_a_q, alu_a_d, alu_b_q, alu_b_d;
  logic [2:0]          alu_op_q, alu_op_d;
  logic                alu_start_q, alu_start_d;
  logic [TW-1:0]       tmo_q, tmo_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [15:0]         rsp_result_q, rsp_result_d;
  logic [2:0]          rsp_op_q, rsp_op_d;
  logic                rsp_err_q, rsp_err_d;
  logic                illegal_q, illegal_d;

  logic                fifo_full, fifo_empty, push, pop, accept, legal;
  logic [CmdWidth-1:0] fifo_rdata;
  logic [2:0]          head_op;
  logic [7:0]          head_a, head_b;

  assign cmd_ready = !fifo_full;
  assign accept    = cmd_valid && cmd_ready;
  assign legal     = is_legal_op(cmd_op);
  // Illegal commands complete the handshake but are never queued.
  assign push      = accept && legal;
  assign {head_op, head_a, head_b} = fifo_rdata;

  tinyalu_cmd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CmdWidth)
  ) u_fifo (
    .clk     (clk),
    .reset_n (reset_n),
    .push    (push),
    .wdata   ({cmd_op, cmd_a, cmd_b}),
    .pop     (pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  always_comb begin
    state_d      = state_q;
    alu_a_d      = alu_a_q;
    alu_b_d      = alu_b_q;
    alu_op_d     = alu_op_q;
    alu_start_d  = alu_start_q;
    tmo_d        = tmo_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_op_d     = rsp_op_q;
    rsp_err_d    = rsp_err_q;
    illegal_d    = accept && !legal;
    pop          = 1'b0;

    unique case (state_q)
      IDLE: begin
        // alu_start is always low on entry, so every command gets a low cycle before it.
        if (!fifo_empty) begin
          pop         = 1'b1;
          alu_a_d     = head_a;
          alu_b_d     = head_b;
          alu_op_d    = head_op;
          alu_start_d = 1'b1;
          tmo_d       = '0;
          state_d     = (head_op == no_op) ? NOOP : ISSUE;
        end
      end
      NOOP: begin
        alu_start_d = 1'b0;
        state_d     = IDLE;
      end
      ISSUE: begin
        if (alu_done) begin
          rsp_result_d = alu_result;
          rsp_op_d     = alu_op_q;
          rsp_err_d    = 1'b0;
          rsp_valid_d  = 1'b1;
          alu_start_d  = 1'b0;
          state_d      = HOLD;
        end else if (tmo_q == TW'(TIMEOUT - 1)) begin
          // Start has now been high for TIMEOUT cycles without done.
          rsp_result_d = '0;
          rsp_op_d     = alu_op_q;
          rsp_err_d    = 1'b1;
          rsp_valid_d  = 1'b1;
          alu_start_d  = 1'b0;
          state_d      = HOLD;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end
      HOLD: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      alu_a_q      <= '0;
      alu_b_q      <= '0;
      alu_op_q     <= '0;
      alu_start_q  <= 1'b0;
      tmo_q        <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_op_q     <= '0;
      rsp_err_q    <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      alu_a_q      <= alu_a_d;
      alu_b_q      <= alu_b_d;
      alu_op_q     <= alu_op_d;
      alu_start_q  <= alu_start_d;
      tmo_q        <= tmo_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_op_q     <= rsp_op_d;
      rsp_err_q    <= rsp_err_d;
      illegal_q    <= illegal_d;
    end
  end

  assign alu_a      = alu_a_q;
  assign alu_b      = alu_b_q;
  assign alu_op     = alu_op_q;
  assign alu_start  = alu_start_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_op     = rsp_op_q;
  assign rsp_err    = rsp_err_q;
  assign illegal_op = illegal_q;

endmodule

// File: tb/tb_tinyalu_cmd_driver.sv
// Self-checking bench for tinyalu_cmd_driver with a behavioural TinyALU responder.
module tb_tinyalu_cmd_driver;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready;
  logic [7:0]  cmd_a, cmd_b;
  logic [2:0]  cmd_op;
  logic [7:0]  alu_a, alu_b;
  logic [2:0]  alu_op;
  logic        alu_start, alu_done;
  logic [15:0] alu_result;
  logic        rsp_valid, rsp_ready;
  logic [15:0] rsp_result;
  logic [2:0]  rsp_op;
  logic        rsp_err, illegal_op;
  logic [2:0]  fifo_level;

  int total = 0;
  int bad   = 0;

  tinyalu_cmd_driver #(
    .FIFO_DEPTH (4),
    .TIMEOUT    (16)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_op     (cmd_op),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_start  (alu_start),
    .alu_done   (alu_done),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_op     (rsp_op),
    .rsp_err    (rsp_err),
    .illegal_op (illegal_op),
    .fifo_level (fifo_level)
  );

  always #5 clk = ~clk;

  // Behavioural ALU: done pulses `lat` cycles after start is seen; no_op never answers.
  int unsigned lat  = 1;
  bit          hang = 1'b0;
  int unsigned mcnt;

  function automatic logic [15:0] calc(input logic [2:0] op, input logic [7:0] a,
                                       input logic [7:0] b);
    case (op)
      3'b001:  return {8'h00, a} + {8'h00, b};
      3'b010:  return {8'h00, a & b};
      3'b011:  return {8'h00, a ^ b};
      3'b100:  return a * b;
      default: return 16'h0000;
    endcase
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mcnt       <= 0;
      alu_done   <= 1'b0;
      alu_result <= '0;
    end else if (alu_start && !alu_done && alu_op != 3'b000 && !hang) begin
      mcnt <= mcnt + 1;
      if (mcnt + 1 == lat) begin
        alu_done   <= 1'b1;
        alu_result <= calc(alu_op, alu_a, alu_b);
      end
    end else begin
      mcnt     <= 0;
      alu_done <= 1'b0;
    end
  end

  // Length (in sampled clock edges) of every alu_start high pulse.
  int unsigned run = 0;
  int unsigned runs[$];
  always @(posedge clk) begin
    if (alu_start) run++;
    else if (run != 0) begin
      runs.push_back(run);
      run = 0;
    end
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  // Called at a negedge; returns at the negedge after the accepting posedge.
  task automatic send(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) check("send_wait", 32'(cmd_ready), 32'd1);
    @(negedge clk);
    cmd_valid = 1'b0;
  endtask

  task automatic get_rsp(input string nm, input logic [15:0] er, input logic [2:0] eo,
                         input logic ee);
    int n = 0;
    while (!rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    check({nm, "_valid"}, 32'(rsp_valid), 32'd1);
    check({nm, "_result"}, 32'(rsp_result), 32'(er));
    check({nm, "_op"}, 32'(rsp_op), 32'(eo));
    check({nm, "_err"}, 32'(rsp_err), 32'(ee));
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check({nm, "_drop"}, 32'(rsp_valid), 32'd0);
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [7:0]  a;
    logic [7:0]  b;
    int unsigned lat;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3'b100, 8'hFF, 8'hFF, 3, 16'hFE01};
    vecs[1] = '{3'b010, 8'hF0, 8'h3C, 1, 16'h0030};
    vecs[2] = '{3'b011, 8'hAA, 8'h55, 2, 16'h00FF};
    vecs[3] = '{3'b001, 8'h80, 8'h80, 1, 16'h0100};
    vecs[4] = '{3'b100, 8'h10, 8'h10, 2, 16'h0100};
    vecs[5] = '{3'b011, 8'h0F, 8'h0F, 4, 16'h0000};

    reset_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0;
    rsp_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_outputs", {alu_start, rsp_valid, rsp_err, illegal_op, alu_op, rsp_op},
          32'd0);
    check("rst_data", {alu_a, alu_b, rsp_result}, 32'd0);
    check("rst_level", 32'(fifo_level), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);

    // Single add with start latency.
    lat = 1;
    send(3'b001, 8'hFF, 8'h01);
    check("lat_start_early", 32'(alu_start), 32'd0);
    check("lat_level1", 32'(fifo_level), 32'd1);
    @(negedge clk);
    check("lat_start_n2", 32'(alu_start), 32'd1);
    check("lat_operands", {alu_op, alu_a, alu_b}, {13'd0, 3'b001, 8'hFF, 8'h01});
    check("lat_level0", 32'(fifo_level), 32'd0);
    get_rsp("add1", 16'h0100, 3'b001, 1'b0);
    check("add1_runs", runs.size(), 32'd1);
    check("add1_run_len", runs[0], 32'd2);

    // Table of single commands with varying ALU latency.
    foreach (vecs[i]) begin
      lat = vecs[i].lat;
      runs.delete();
      send(vecs[i].op, vecs[i].a, vecs[i].b);
      get_rsp($sformatf("vec%0d", i), vecs[i].exp, vecs[i].op, 1'b0);
      check($sformatf("vec%0d_run", i), runs[0], vecs[i].lat + 1);
    end

    // Queued mul/and/xor: in-order responses, start separated by low cycles.
    lat = 1;
    runs.delete();
    send(3'b100, 8'hFF, 8'hFF);
    send(3'b010, 8'hF0, 8'h3C);
    send(3'b011, 8'hAA, 8'h55);
    get_rsp("q_mul", 16'hFE01, 3'b100, 1'b0);
    get_rsp("q_and", 16'h0030, 3'b010, 1'b0);
    get_rsp("q_xor", 16'h00FF, 3'b011, 1'b0);
    check("q_runs", runs.size(), 32'd3);
    foreach (runs[i]) check("q_run_len", runs[i], 32'd2);

    // Back-to-back adds with responses stalled: FIFO fills, then drains in order.
    runs.delete();
    for (int i = 0; i < 5; i++) send(3'b001, 8'(i), 8'h10);
    check("full_ready", 32'(cmd_ready), 32'd0);
    check("full_level", 32'(fifo_level), 32'd4);
    check("full_rsp_held", 32'(rsp_valid), 32'd1);
    fork
      send(3'b001, 8'd5, 8'h10);
      begin
        for (int i = 0; i < 6; i++) get_rsp($sformatf("b2b%0d", i), 16'(16 + i), 3'b001, 1'b0);
      end
    join
    check("b2b_runs", runs.size(), 32'd6);
    check("b2b_level", 32'(fifo_level), 32'd0);

    // no_op, illegal opcode, add.
    runs.delete();
    send(3'b000, 8'h11, 8'h22);
    send(3'b110, 8'h33, 8'h44);
    check("illegal_pulse", 32'(illegal_op), 32'd1);
    send(3'b001, 8'h01, 8'h02);
    check("illegal_clear", 32'(illegal_op), 32'd0);
    get_rsp("after_noop", 16'h0003, 3'b001, 1'b0);
    check("noop_runs", runs.size(), 32'd2);
    check("noop_run_len", runs[0], 32'd1);
    check("noop_add_run_len", runs[1], 32'd2);
    repeat (3) @(negedge clk);
    check("noop_no_extra_rsp", 32'(rsp_valid), 32'd0);

    // Timeout abort, then the queued command proceeds normally.
    runs.delete();
    hang = 1'b1;
    send(3'b001, 8'h03, 8'h04);
    send(3'b001, 8'h07, 8'h08);
    get_rsp("tmo", 16'h0000, 3'b001, 1'b1);
    hang = 1'b0;
    check("tmo_run_len", runs[0], 32'd16);
    get_rsp("tmo_next", 16'h000F, 3'b001, 1'b0);

    // Reset during a mul with two commands queued.
    lat = 5;
    send(3'b100, 8'h09, 8'h09);
    send(3'b001, 8'h01, 8'h01);
    send(3'b001, 8'h02, 8'h02);
    check("mid_start_high", 32'(alu_start), 32'd1);
    reset_n = 1'b0;
    #1;
    check("mid_rst_start", 32'(alu_start), 32'd0);
    check("mid_rst_level", 32'(fifo_level), 32'd0);
    check("mid_rst_rsp", 32'(rsp_valid), 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    runs.delete();
    lat = 1;
    send(3'b001, 8'h05, 8'h05);
    get_rsp("post_rst", 16'h000A, 3'b001, 1'b0);
    repeat (4) @(negedge clk);
    check("post_rst_idle", {30'd0, rsp_valid, alu_start}, 32'd0);
    check("post_rst_runs", runs.size(), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
